pika_match_ctrl: RTL and testbench

- Match sequencer for the PikaBall game. Drives the shared Game_state bus consumed by both player blocks and the ball block.
- Game_state value 1 makes every player block snap back to its spawn position.
- Detects ball landings, awards points, chooses the serving side, runs the serve and point delays, and declares the winner.

---
 rtl/pika_match_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pika_match_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pika_match_ctrl.sv
// PikaBall match sequencer: drives the shared game-state bus, scores ball landings,
// picks the serving side and times the serve, point-freeze and game-over delays.
module pika_match_ctrl #(
    parameter int unsigned NET_X     = 160,
    parameter int unsigned WIN_SCORE = 15,
    parameter int unsigned SERVE_CYC = 50000000,
    parameter int unsigned POINT_CYC = 100000000,
    parameter int unsigned OVER_CYC  = 100000000,
    parameter int unsigned CNT_W     = 27
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_btn,
    input  logic        ball_land,
    input  logic [11:0] ball_x,
    output logic [1:0]  game_state,
    output logic        freeze,
    output logic        serve_right,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        point_pulse,
    output logic        winner_right
);

    localparam int unsigned X_W     = 12;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned GS_W    = 2;

    localparam logic [X_W-1:0]     NET_POS    = X_W'(NET_X);
    localparam logic [SCORE_W-1:0] WIN_PTS    = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_CYC - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_CYC - 1);
    localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(OVER_CYC - 1);

    localparam logic [GS_W-1:0] GS_TITLE = GS_W'(0);
    localparam logic [GS_W-1:0] GS_SERVE = GS_W'(1);
    localparam logic [GS_W-1:0] GS_PLAY  = GS_W'(2);
    localparam logic [GS_W-1:0] GS_OVER  = GS_W'(3);

    typedef enum logic [2:0] {
        ST_TITLE,
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_OVER
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_last;
    logic               cnt_run;
    logic               start_q;
    logic               start_rise;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic [SCORE_W-1:0] scorer_pts;
    logic               serve_right_q, serve_right_d;
    logic               point_pulse_q, point_pulse_d;
    logic               winner_right_q, winner_right_d;
    logic [GS_W-1:0]    game_state_q, game_state_d;
    logic               freeze_q, freeze_d;

    assign start_rise = start_btn & ~start_q;
    assign scorer_pts = serve_right_q ? score_r_q : score_l_q;

    // Next-state, scoring and delay-counter logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cnt_last       = '0;
        cnt_run        = 1'b0;
        score_l_d      = score_l_q;
        score_r_d      = score_r_q;
        serve_right_d  = serve_right_q;
        point_pulse_d  = 1'b0;
        winner_right_d = winner_right_q;
        game_state_d   = GS_TITLE;
        freeze_d       = 1'b0;

        case (state_q)
            ST_TITLE: begin
                if (start_rise) begin
                    score_l_d      = '0;
                    score_r_d      = '0;
                    serve_right_d  = 1'b1;
                    winner_right_d = 1'b0;
                    state_d        = ST_SERVE;
                end
            end
            ST_SERVE: begin
                cnt_run  = 1'b1;
                cnt_last = SERVE_LAST;
                if (cnt_q == SERVE_LAST) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (ball_land) begin
                    point_pulse_d = 1'b1;
                    state_d       = ST_POINT;
                    // Landing left of the net is a point for the right player
                    if (ball_x < NET_POS) begin
                        serve_right_d = 1'b1;
                        if (score_r_q != WIN_PTS) begin
                            score_r_d = score_r_q + SCORE_W'(1);
                        end
                    end else begin
                        serve_right_d = 1'b0;
                        if (score_l_q != WIN_PTS) begin
                            score_l_d = score_l_q + SCORE_W'(1);
                        end
                    end
                end
            end
            ST_POINT: begin
                cnt_run  = 1'b1;
                cnt_last = POINT_LAST;
                if (cnt_q == POINT_LAST) begin
                    if (scorer_pts == WIN_PTS) begin
                        state_d        = ST_OVER;
                        winner_right_d = (score_r_q == WIN_PTS);
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                cnt_run  = 1'b1;
                cnt_last = OVER_LAST;
                if (start_rise && (cnt_q == OVER_LAST)) begin
                    state_d = ST_TITLE;
                end
            end
            default: begin
                state_d = ST_TITLE;
            end
        endcase

        // Counter restarts on any state change and parks at the state's terminal count
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_run && (cnt_q != cnt_last)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_d)
            ST_SERVE: game_state_d = GS_SERVE;
            ST_PLAY:  game_state_d = GS_PLAY;
            ST_POINT: game_state_d = GS_PLAY;
            ST_OVER:  game_state_d = GS_OVER;
            default:  game_state_d = GS_TITLE;
        endcase
        freeze_d = (state_d == ST_POINT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_TITLE;
            cnt_q          <= '0;
            start_q        <= 1'b0;
            score_l_q      <= '0;
            score_r_q      <= '0;
            serve_right_q  <= 1'b1;
            point_pulse_q  <= 1'b0;
            winner_right_q <= 1'b0;
            game_state_q   <= GS_TITLE;
            freeze_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            start_q        <= start_btn;
            score_l_q      <= score_l_d;
            score_r_q      <= score_r_d;
            serve_right_q  <= serve_right_d;
            point_pulse_q  <= point_pulse_d;
            winner_right_q <= winner_right_d;
            game_state_q   <= game_state_d;
            freeze_q       <= freeze_d;
        end
    end

    assign game_state   = game_state_q;
    assign freeze       = freeze_q;
    assign serve_right  = serve_right_q;
    assign score_l      = score_l_q;
    assign score_r      = score_r_q;
    assign point_pulse  = point_pulse_q;
    assign winner_right = winner_right_q;

endmodule

// File: tb/tb_pika_match_ctrl.sv
// Bench for pika_match_ctrl: table of rallies, hand-written delay/boundary sequences,
// then randomized traffic checked against a timestamp-based match model.
module tb_pika_match_ctrl;

    localparam int unsigned T_NET   = 160;
    localparam int unsigned T_WIN   = 2;
    localparam int unsigned T_SERVE = 4;
    localparam int unsigned T_POINT = 3;
    localparam int unsigned T_OVER  = 5;

    logic        clk;
    logic        reset_n;
    logic        start_btn;
    logic        ball_land;
    logic [11:0] ball_x;
    logic [1:0]  game_state;
    logic        freeze;
    logic        serve_right;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic        point_pulse;
    logic        winner_right;

    pika_match_ctrl #(
        .NET_X     (T_NET),
        .WIN_SCORE (T_WIN),
        .SERVE_CYC (T_SERVE),
        .POINT_CYC (T_POINT),
        .OVER_CYC  (T_OVER),
        .CNT_W     (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_btn    (start_btn),
        .ball_land    (ball_land),
        .ball_x       (ball_x),
        .game_state   (game_state),
        .freeze       (freeze),
        .serve_right  (serve_right),
        .score_l      (score_l),
        .score_r      (score_r),
        .point_pulse  (point_pulse),
        .winner_right (winner_right)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [11:0] x;
        int          sl;
        int          sr;
        bit          srv;
        int          next_gs;
        bit          win;
    } rally_t;

    rally_t rows[6];

    // Match model: phases tracked by (shown game_state, frozen) and the edge index of entry
    bit model_on = 1'b0;
    int m_cyc = 0;
    int m_t0  = 0;
    int m_gs, m_sl, m_sr;
    bit m_frz, m_srv, m_pulse, m_win, m_prev;

    task automatic model_reset();
        m_gs = 0; m_frz = 0; m_srv = 1; m_sl = 0; m_sr = 0;
        m_pulse = 0; m_win = 0; m_prev = 0; m_t0 = m_cyc;
    endtask

    task automatic model_step(input logic rst_n, input logic st, input logic land,
                              input logic [11:0] x);
        bit rise;
        int held;
        int pts;
        m_cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise    = st && !m_prev;
        m_prev  = st;
        m_pulse = 0;
        held    = m_cyc - m_t0;
        if (m_gs == 0) begin
            if (rise) begin
                m_sl = 0; m_sr = 0; m_srv = 1; m_win = 0; m_gs = 1; m_t0 = m_cyc;
            end
        end else if (m_gs == 1) begin
            if (held >= T_SERVE) begin m_gs = 2; m_t0 = m_cyc; end
        end else if (m_gs == 2 && !m_frz) begin
            if (land) begin
                m_srv = (int'(x) < T_NET);
                if (m_srv) m_sr = (m_sr < T_WIN) ? m_sr + 1 : m_sr;
                else       m_sl = (m_sl < T_WIN) ? m_sl + 1 : m_sl;
                m_pulse = 1; m_frz = 1; m_t0 = m_cyc;
            end
        end else if (m_gs == 2) begin
            if (held >= T_POINT) begin
                m_frz = 0; m_t0 = m_cyc;
                pts = m_srv ? m_sr : m_sl;
                if (pts == T_WIN) begin
                    m_gs = 3; m_win = (m_sr == T_WIN);
                end else begin
                    m_gs = 1;
                end
            end
        end else begin
            if (rise && held >= T_OVER) begin m_gs = 0; m_t0 = m_cyc; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on) model_step(reset_n, start_btn, ball_land, ball_x);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_play();
        for (int i = 0; i < 50; i++) begin
            if (game_state == 2'd2 && !freeze) break;
            tick();
        end
        check("reach_play", 32'(game_state == 2'd2 && !freeze), 1);
    endtask

    // One rally: landing with a simultaneous start press, a stray landing while frozen
    task automatic rally(input rally_t r);
        int nfrz;
        wait_play();
        ball_land = 1'b1; ball_x = r.x; start_btn = 1'b1;
        tick();
        ball_land = 1'b0; start_btn = 1'b0;
        check("land_pulse",   point_pulse, 1);
        check("land_score_l", score_l, r.sl);
        check("land_score_r", score_r, r.sr);
        check("land_serve_r", serve_right, 32'(r.srv));
        check("land_freeze",  freeze, 1);
        check("land_gs",      game_state, 2);
        nfrz = 1;
        ball_land = 1'b1; ball_x = 12'd100;
        tick();
        ball_land = 1'b0;
        check("point_land_pulse", point_pulse, 0);
        check("point_land_sr",    score_r, r.sr);
        if (freeze) nfrz++;
        for (int i = 0; i < 20 && freeze; i++) begin
            tick();
            if (freeze) nfrz++;
        end
        check("freeze_len", nfrz, T_POINT);
        check("after_point_gs", game_state, r.next_gs);
        if (r.next_gs == 3) check("winner", winner_right, 32'(r.win));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [13:0] got, exp;

        rows[0] = '{12'd100,  0, 1, 1'b1, 1, 1'b0};
        rows[1] = '{12'd160,  1, 1, 1'b0, 1, 1'b0};
        rows[2] = '{12'd319,  2, 1, 1'b0, 3, 1'b0};
        rows[3] = '{12'd159,  0, 1, 1'b1, 1, 1'b0};
        rows[4] = '{12'd4095, 1, 1, 1'b0, 1, 1'b0};
        rows[5] = '{12'd0,    1, 2, 1'b1, 3, 1'b1};

        reset_n = 1'b0; start_btn = 1'b0; ball_land = 1'b0; ball_x = '0;
        tick(); tick();
        check("rst_gs", game_state, 0);
        check("rst_freeze", freeze, 0);
        check("rst_serve_r", serve_right, 1);
        check("rst_scores", {score_l, score_r}, 0);
        check("rst_pulse", point_pulse, 0);
        check("rst_winner", winner_right, 0);
        reset_n = 1'b1;
        tick();
        check("title_idle", game_state, 0);

        // Start press: SERVE shows for exactly T_SERVE cycles, start held high meanwhile
        start_btn = 1'b1;
        tick();
        check("start_gs", game_state, 1);
        check("start_scores", {score_l, score_r}, 0);
        check("start_serve_r", serve_right, 1);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (game_state != 2'd1) break;
            n++;
        end
        start_btn = 1'b0;
        check("serve_len", n, T_SERVE);
        check("serve_to_play", game_state, 2);

        for (int i = 0; i < 3; i++) rally(rows[i]);

        // OVER: early start press ignored, later accepted; scores survive into TITLE
        tick();
        start_btn = 1'b1;
        tick();
        check("over_early_start", game_state, 3);
        start_btn = 1'b0;
        repeat (6) tick();
        check("over_hold", game_state, 3);
        check("over_scores", {score_l, score_r}, {4'd2, 4'd1});
        start_btn = 1'b1;
        tick();
        check("over_to_title", game_state, 0);
        check("title_scores_kept", {score_l, score_r}, {4'd2, 4'd1});
        check("title_winner_kept", winner_right, 0);
        repeat (5) tick();
        check("held_no_autostart", game_state, 0);
        ball_land = 1'b1; ball_x = 12'd100;
        tick();
        ball_land = 1'b0;
        check("title_land_pulse", point_pulse, 0);
        check("title_land_sr", score_r, 1);
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check("restart_gs", game_state, 1);
        check("restart_scores", {score_l, score_r}, 0);
        check("restart_serve_r", serve_right, 1);
        ball_land = 1'b1; ball_x = 12'd100;
        tick();
        ball_land = 1'b0;
        check("serve_land_pulse", point_pulse, 0);
        check("serve_land_sr", score_r, 0);
        check("serve_land_gs", game_state, 1);

        for (int i = 3; i < 6; i++) rally(rows[i]);

        // Start accepted exactly when OVER has lasted T_OVER cycles
        tick(); tick();
        start_btn = 1'b1;
        tick();
        check("over2_early", game_state, 3);
        start_btn = 1'b0;
        tick();
        check("over2_still", game_state, 3);
        start_btn = 1'b1;
        tick();
        check("over2_exit", game_state, 0);
        check("over2_winner_kept", winner_right, 1);
        check("over2_scores", {score_l, score_r}, {4'd1, 4'd2});

        // Reset in the middle of a point freeze
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        wait_play();
        ball_land = 1'b1; ball_x = 12'd200;
        tick();
        ball_land = 1'b0;
        check("midpt_score_l", score_l, 1);
        tick();
        check("midpt_freeze", freeze, 1);
        reset_n = 1'b0;
        tick();
        check("midpt_rst", {game_state, freeze, serve_right, score_l, score_r,
                            point_pulse, winner_right}, 14'b00_0_1_0000_0000_0_0);

        // Randomized traffic against the model
        model_reset();
        model_on = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) start_btn = ~start_btn;
            ball_land = ($urandom_range(0, 3) == 0);
            ball_x    = ($urandom_range(0, 1) == 1) ? 12'(155 + $urandom_range(0, 10))
                                                    : 12'($urandom);
            reset_n   = ($urandom_range(0, 499) != 0);
            tick();
            got = {game_state, freeze, serve_right, score_l, score_r, point_pulse, winner_right};
            exp = {2'(m_gs), m_frz, m_srv, 4'(m_sl), 4'(m_sr), m_pulse, m_win};
            check("rand_cycle", 32'(got), 32'(exp));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
